// File: rtl/micro_sequencer_pkg.sv
// Shared constants for the shared-bus computer sequencer: opcodes, FSM states,
// micro-step indices and control-word bit positions.
package board_pkg;

    localparam int unsigned OPC_W  = 4;
    localparam int unsigned STEP_W = 3;
    localparam int unsigned ST_W   = 2;
    localparam int unsigned CW_W   = 15;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OP_STA = 4'h4;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_HALT = 2'd2;

    localparam logic [STEP_W-1:0] T0 = 3'd0;
    localparam logic [STEP_W-1:0] T1 = 3'd1;
    localparam logic [STEP_W-1:0] T2 = 3'd2;
    localparam logic [STEP_W-1:0] T3 = 3'd3;
    localparam logic [STEP_W-1:0] T4 = 3'd4;

    // Control word field order, MSB first.
    localparam int unsigned CW_MARWA    = 14;
    localparam int unsigned CW_RAMWA    = 13;
    localparam int unsigned CW_RAMOA    = 12;
    localparam int unsigned CW_INREGOA  = 11;
    localparam int unsigned CW_INREGWA  = 10;
    localparam int unsigned CW_AWA      = 9;
    localparam int unsigned CW_AOA      = 8;
    localparam int unsigned CW_SUMOUT   = 7;
    localparam int unsigned CW_SUB      = 6;
    localparam int unsigned CW_BWA      = 5;
    localparam int unsigned CW_OUTREGWA = 4;
    localparam int unsigned CW_PCINC    = 3;
    localparam int unsigned CW_PCOE     = 2;
    localparam int unsigned CW_PCJMP    = 1;
    localparam int unsigned CW_FLAGSIN  = 0;

    typedef logic [CW_W-1:0] ctrl_word_t;

    // Final active micro-step of each opcode; unlisted opcodes behave as NOP.
    function automatic logic [STEP_W-1:0] last_step_of(input logic [OPC_W-1:0] op);
        case (op)
            OP_LDA, OP_STA:                                    return T3;
            OP_ADD, OP_SUB:                                    return T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:      return T2;
            default:                                           return T1;
        endcase
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Datapath-facing signal bundle of the sequencer. SINGLE_STEP_EN adds step_mode/step_req.
interface micro_sequencer_if;
    import board_pkg::*;

    logic               run;
    logic [OPC_W-1:0]   opcode;
    logic               cf;
    logic               zf;
`ifdef SINGLE_STEP_EN
    logic               step_mode;
    logic               step_req;
`endif
    logic               hlt;
    logic               marwa, ramwa, ramoa, inregoa, inregwa, awa, aoa, sumout;
    logic               sub, bwa, outregwa, pcinc, pcoe, pcjmp, flagsin;
    logic [STEP_W-1:0]  step;
    logic               instr_done;
    logic               halted;

    modport master (
`ifdef SINGLE_STEP_EN
        output step_mode, output step_req,
`endif
        output run, output opcode, output cf, output zf,
        input  hlt, input marwa, input ramwa, input ramoa, input inregoa, input inregwa,
        input  awa, input aoa, input sumout, input sub, input bwa, input outregwa,
        input  pcinc, input pcoe, input pcjmp, input flagsin,
        input  step, input instr_done, input halted
    );

    modport slave (
`ifdef SINGLE_STEP_EN
        input  step_mode, input step_req,
`endif
        input  run, input opcode, input cf, input zf,
        output hlt, output marwa, output ramwa, output ramoa, output inregoa, output inregwa,
        output awa, output aoa, output sumout, output sub, output bwa, output outregwa,
        output pcinc, output pcoe, output pcjmp, output flagsin,
        output step, output instr_done, output halted
    );

endinterface

// File: rtl/micro_decoder.sv
// Combinational micro-op decode: (opcode, step, flags) -> control word, last-step and halt.
module micro_decoder
    import board_pkg::*;
(
    input  logic [OPC_W-1:0]  i_opcode,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_cf,
    input  logic              i_zf,
    output ctrl_word_t        o_cw_c,
    output logic              o_last_c,
    output logic              o_halt_c
);

    always_comb begin
        o_cw_c   = '0;
        o_halt_c = 1'b0;
        o_last_c = (i_step == last_step_of(i_opcode));
        case (i_step)
            T0: begin
                o_cw_c[CW_PCOE]  = 1'b1;
                o_cw_c[CW_MARWA] = 1'b1;
            end
            T1: begin
                o_cw_c[CW_RAMOA]   = 1'b1;
                o_cw_c[CW_INREGWA] = 1'b1;
                o_cw_c[CW_PCINC]   = 1'b1;
            end
            T2: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        o_cw_c[CW_INREGOA] = 1'b1;
                        o_cw_c[CW_MARWA]   = 1'b1;
                    end
                    OP_LDI: begin
                        o_cw_c[CW_INREGOA] = 1'b1;
                        o_cw_c[CW_AWA]     = 1'b1;
                    end
                    OP_JMP: begin
                        o_cw_c[CW_INREGOA] = 1'b1;
                        o_cw_c[CW_PCJMP]   = 1'b1;
                    end
                    OP_JC: begin
                        o_cw_c[CW_INREGOA] = 1'b1;
                        o_cw_c[CW_PCJMP]   = i_cf;
                    end
                    OP_JZ: begin
                        o_cw_c[CW_INREGOA] = 1'b1;
                        o_cw_c[CW_PCJMP]   = i_zf;
                    end
                    OP_OUT: begin
                        o_cw_c[CW_AOA]      = 1'b1;
                        o_cw_c[CW_OUTREGWA] = 1'b1;
                    end
                    OP_HLT:  o_halt_c = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                case (i_opcode)
                    OP_LDA: begin
                        o_cw_c[CW_RAMOA] = 1'b1;
                        o_cw_c[CW_AWA]   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        o_cw_c[CW_RAMOA] = 1'b1;
                        o_cw_c[CW_BWA]   = 1'b1;
                    end
                    OP_STA: begin
                        o_cw_c[CW_AOA]   = 1'b1;
                        o_cw_c[CW_RAMWA] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                    o_cw_c[CW_SUMOUT]  = 1'b1;
                    o_cw_c[CW_AWA]     = 1'b1;
                    o_cw_c[CW_FLAGSIN] = 1'b1;
                    o_cw_c[CW_SUB]     = (i_opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Hardwired fetch/execute sequencer: IDLE/RUN/HALT FSM, step counter and control gating.
// Optional build macro: SINGLE_STEP_EN (manual step advance via step_mode/step_req).
module micro_sequencer
    import board_pkg::*;
#(
    parameter bit          EARLY_RETURN = 1'b1,
    parameter int unsigned LAST_STEP    = 4
) (
    input  logic               clk,
    input  logic               clr,
    micro_sequencer_if.slave   bus
);

    logic [ST_W-1:0]   r_state, w_state_nxt;
    logic [STEP_W-1:0] r_step,  w_step_nxt;
    logic              r_halted;
    ctrl_word_t        w_dec_cw, w_cw;
    logic              w_dec_last, w_dec_halt;
    logic              w_done, w_hlt, w_adv;

    micro_decoder u_dec (
        .i_opcode (bus.opcode),
        .i_step   (r_step),
        .i_cf     (bus.cf),
        .i_zf     (bus.zf),
        .o_cw_c   (w_dec_cw),
        .o_last_c (w_dec_last),
        .o_halt_c (w_dec_halt)
    );

`ifdef SINGLE_STEP_EN
    assign w_adv = ~bus.step_mode | bus.step_req;
`else
    assign w_adv = 1'b1;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state  <= ST_IDLE;
            r_step   <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_step   <= w_step_nxt;
            r_halted <= (w_state_nxt == ST_HALT);
        end
    end

    // Controls only leave the decoder on cycles where RUN actually advances.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_cw        = '0;
        w_done      = 1'b0;
        w_hlt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.run) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_adv) begin
                    w_cw   = w_dec_cw;
                    w_done = w_dec_last;
                    w_hlt  = w_dec_halt;
                    if (w_dec_halt)
                        w_state_nxt = ST_HALT;
                    else if ((EARLY_RETURN && w_dec_last) || (r_step == STEP_W'(LAST_STEP)))
                        w_step_nxt = '0;
                    else
                        w_step_nxt = r_step + STEP_W'(1);
                end
            end
            ST_HALT: w_hlt = 1'b1;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.marwa      = w_cw[CW_MARWA];
    assign bus.ramwa      = w_cw[CW_RAMWA];
    assign bus.ramoa      = w_cw[CW_RAMOA];
    assign bus.inregoa    = w_cw[CW_INREGOA];
    assign bus.inregwa    = w_cw[CW_INREGWA];
    assign bus.awa        = w_cw[CW_AWA];
    assign bus.aoa        = w_cw[CW_AOA];
    assign bus.sumout     = w_cw[CW_SUMOUT];
    assign bus.sub        = w_cw[CW_SUB];
    assign bus.bwa        = w_cw[CW_BWA];
    assign bus.outregwa   = w_cw[CW_OUTREGWA];
    assign bus.pcinc      = w_cw[CW_PCINC];
    assign bus.pcoe       = w_cw[CW_PCOE];
    assign bus.pcjmp      = w_cw[CW_PCJMP];
    assign bus.flagsin    = w_cw[CW_FLAGSIN];
    assign bus.step       = r_step;
    assign bus.instr_done = w_done;
    assign bus.hlt        = w_hlt;
    assign bus.halted     = r_halted;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench: directed vector table, corner sequences and a randomized run
// against a micro-program reference model, for EARLY_RETURN=1 and EARLY_RETURN=0.
module tb_micro_sequencer;

    localparam logic [14:0] MW = 15'h4000, RW = 15'h2000, RO = 15'h1000, IO = 15'h0800;
    localparam logic [14:0] IW = 15'h0400, AW = 15'h0200, AO = 15'h0100, SO = 15'h0080;
    localparam logic [14:0] SB = 15'h0040, BW = 15'h0020, OW = 15'h0010, PI = 15'h0008;
    localparam logic [14:0] PO = 15'h0004, PJ = 15'h0002, FI = 15'h0001;
    localparam logic [14:0] F0 = PO | MW;
    localparam logic [14:0] F1 = RO | IW | PI;

    logic clk;
    logic clr;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    micro_sequencer_if b1 ();
    micro_sequencer_if b0 ();

    micro_sequencer #(.EARLY_RETURN(1'b1), .LAST_STEP(4)) u_er1 (.clk(clk), .clr(clr), .bus(b1.slave));
    micro_sequencer #(.EARLY_RETURN(1'b0), .LAST_STEP(4)) u_er0 (.clk(clk), .clr(clr), .bus(b0.slave));

    // Observed: {step, hlt, halted, instr_done, control word}
    logic [20:0] obs1, obs0;
    logic [4:0]  drv1, drv0;
    assign obs1 = {b1.step, b1.hlt, b1.halted, b1.instr_done, b1.marwa, b1.ramwa, b1.ramoa,
                   b1.inregoa, b1.inregwa, b1.awa, b1.aoa, b1.sumout, b1.sub, b1.bwa,
                   b1.outregwa, b1.pcinc, b1.pcoe, b1.pcjmp, b1.flagsin};
    assign obs0 = {b0.step, b0.hlt, b0.halted, b0.instr_done, b0.marwa, b0.ramwa, b0.ramoa,
                   b0.inregoa, b0.inregwa, b0.awa, b0.aoa, b0.sumout, b0.sub, b0.bwa,
                   b0.outregwa, b0.pcinc, b0.pcoe, b0.pcjmp, b0.flagsin};
    assign drv1 = {b1.pcoe, b1.ramoa, b1.inregoa, b1.aoa, b1.sumout};
    assign drv0 = {b0.pcoe, b0.ramoa, b0.inregoa, b0.aoa, b0.sumout};

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  op;
        logic        cf;
        logic        zf;
        int          t;
        logic [14:0] cw;
        logic        done;
        logic        hlt;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic run, input logic [3:0] op, input logic cf, input logic zf);
        b1.run = run; b1.opcode = op; b1.cf = cf; b1.zf = zf;
        b0.run = run; b0.opcode = op; b0.cf = cf; b0.zf = zf;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        #1;
        clr = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int last_of(input logic [3:0] op);
        case (op)
            4'h1, 4'h4:                         return 3;
            4'h2, 4'h3:                         return 4;
            4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: return 2;
            default:                            return 1;
        endcase
    endfunction

    // Micro-program table: one row of five step words per opcode.
    function automatic logic [14:0] prog_word(input logic [3:0] op, input int t,
                                              input logic cf, input logic zf);
        logic [14:0] row [5];
        row = '{F0, F1, 15'h0, 15'h0, 15'h0};
        case (op)
            4'h1: begin row[2] = IO | MW; row[3] = RO | AW; end
            4'h2: begin row[2] = IO | MW; row[3] = RO | BW; row[4] = SO | AW | FI; end
            4'h3: begin row[2] = IO | MW; row[3] = RO | BW; row[4] = SO | AW | FI | SB; end
            4'h4: begin row[2] = IO | MW; row[3] = AO | RW; end
            4'h5: row[2] = IO | AW;
            4'h6: row[2] = IO | PJ;
            4'h7: row[2] = IO | (cf ? PJ : 15'h0);
            4'h8: row[2] = IO | (zf ? PJ : 15'h0);
            4'hE: row[2] = AO | OW;
            default: ;
        endcase
        return row[t];
    endfunction

    // Reference: st 0=idle 1=run 2=halt; returns expected outputs and the post-edge state.
    task automatic model(input int st, input int stp, input logic [3:0] op, input logic cf,
                         input logic zf, input logic run, input bit er,
                         output logic [20:0] exp, output int nst, output int nstp);
        logic [14:0] cw;
        logic        done;
        logic        hlt;
        int          last;
        cw = 15'h0; done = 1'b0; hlt = 1'b0;
        last = last_of(op);
        nst = st; nstp = stp;
        if (st == 0) begin
            if (run) nst = 1;
        end else if (st == 2) begin
            hlt = 1'b1;
        end else begin
            if (stp <= last) begin
                cw   = prog_word(op, stp, cf, zf);
                done = (stp == last);
            end
            if (op == 4'hF && stp == 2) begin
                hlt = 1'b1;
                nst = 2;
            end else if (er && stp == last) begin
                nstp = 0;
            end else begin
                nstp = (stp + 1) % 5;
            end
        end
        exp = {3'(stp), hlt, (st == 2), done, cw};
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [20:0] e1, e0;
        int m1s, m1p, m0s, m0p, n1s, n1p, n0s, n0p, hc;
        logic [3:0]  rop;
        logic [14:0] ldi_w [5];

        vecs[0]  = '{4'h1, 1'b0, 1'b0, 0, F0,            1'b0, 1'b0};
        vecs[1]  = '{4'h1, 1'b0, 1'b0, 1, F1,            1'b0, 1'b0};
        vecs[2]  = '{4'h1, 1'b0, 1'b0, 2, IO | MW,       1'b0, 1'b0};
        vecs[3]  = '{4'h1, 1'b0, 1'b0, 3, RO | AW,       1'b1, 1'b0};
        vecs[4]  = '{4'h3, 1'b0, 1'b0, 4, SO|AW|FI|SB,   1'b1, 1'b0};
        vecs[5]  = '{4'h2, 1'b0, 1'b0, 3, RO | BW,       1'b0, 1'b0};
        vecs[6]  = '{4'h7, 1'b0, 1'b1, 2, IO,            1'b1, 1'b0};
        vecs[7]  = '{4'h7, 1'b1, 1'b0, 2, IO | PJ,       1'b1, 1'b0};
        vecs[8]  = '{4'h8, 1'b0, 1'b1, 2, IO | PJ,       1'b1, 1'b0};
        vecs[9]  = '{4'h8, 1'b1, 1'b0, 2, IO,            1'b1, 1'b0};
        vecs[10] = '{4'h0, 1'b0, 1'b0, 1, F1,            1'b1, 1'b0};
        vecs[11] = '{4'h4, 1'b0, 1'b0, 3, AO | RW,       1'b1, 1'b0};
        vecs[12] = '{4'h5, 1'b0, 1'b0, 2, IO | AW,       1'b1, 1'b0};
        vecs[13] = '{4'hE, 1'b0, 1'b0, 2, AO | OW,       1'b1, 1'b0};
        vecs[14] = '{4'hB, 1'b0, 1'b0, 1, F1,            1'b1, 1'b0};
        vecs[15] = '{4'h6, 1'b0, 1'b0, 2, IO | PJ,       1'b1, 1'b0};
        vecs[16] = '{4'hF, 1'b0, 1'b0, 2, 15'h0,         1'b1, 1'b1};

        // Reset holds everything low even with run asserted.
        clr = 1'b0;
        set_in(1'b1, 4'h2, 1'b1, 1'b1);
        tick();
        check("reset_er1", obs1, 21'h0);
        check("reset_er0", obs0, 21'h0);
        set_in(1'b0, 4'h0, 1'b0, 1'b0);
        clr = 1'b1;

        // Directed table: reach step t from reset, compare both configurations.
        for (int i = 0; i < 17; i++) begin
            do_reset();
            set_in(1'b1, vecs[i].op, vecs[i].cf, vecs[i].zf);
            tick();
            for (int k = 0; k < vecs[i].t; k++) tick();
            check($sformatf("vec%0d_er1", i), obs1,
                  {3'(vecs[i].t), vecs[i].hlt, 1'b0, vecs[i].done, vecs[i].cw});
            check($sformatf("vec%0d_er0", i), obs0,
                  {3'(vecs[i].t), vecs[i].hlt, 1'b0, vecs[i].done, vecs[i].cw});
        end

        // Asynchronous reset in the middle of ADD T3.
        do_reset();
        set_in(1'b1, 4'h2, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) tick();
        check("add_t3", obs1, {3'd3, 1'b0, 1'b0, 1'b0, RO | BW});
        #2 clr = 1'b0;
        #1;
        check("rst_mid_er1", obs1, 21'h0);
        check("rst_mid_er0", obs0, 21'h0);
        #1 clr = 1'b1;
        set_in(1'b0, 4'h2, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("idle%0d", k), obs1, 21'h0);
        end
        set_in(1'b1, 4'h2, 1'b0, 1'b0);
        tick();
        check("idle_exit", obs1, {3'd0, 1'b0, 1'b0, 1'b0, F0});

        // HLT: terminal, step frozen at 2, inputs ignored.
        do_reset();
        set_in(1'b1, 4'hF, 1'b0, 1'b0);
        tick(); tick(); tick();
        tick();
        for (int k = 0; k < 20; k++) begin
            set_in(k[0], 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
            #3;
            check($sformatf("halt%0d_er1", k), obs1, {3'd2, 1'b1, 1'b1, 1'b0, 15'h0});
            check($sformatf("halt%0d_er0", k), obs0, {3'd2, 1'b1, 1'b1, 1'b0, 15'h0});
            tick();
        end

        // EARLY_RETURN=0 with LDI: T3/T4 idle, wrap after T4.
        ldi_w = '{F0, F1, IO | AW, 15'h0, 15'h0};
        do_reset();
        set_in(1'b1, 4'h5, 1'b0, 1'b0);
        tick();
        for (int t = 0; t < 5; t++) begin
            check($sformatf("ldi_er0_t%0d", t), obs0, {3'(t), 1'b0, 1'b0, (t == 2), ldi_w[t]});
            tick();
        end
        check("ldi_er0_wrap", obs0, {3'd0, 1'b0, 1'b0, 1'b0, F0});

        // Randomized run against the reference model.
        do_reset();
        m1s = 0; m1p = 0; m0s = 0; m0p = 0; hc = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hc >= 8) begin
                do_reset();
                m1s = 0; m1p = 0; m0s = 0; m0p = 0; hc = 0;
            end
            rop = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            set_in(($urandom_range(0, 3) != 0), rop, 1'($urandom), 1'($urandom));
            #3;
            model(m1s, m1p, rop, b1.cf, b1.zf, b1.run, 1'b1, e1, n1s, n1p);
            model(m0s, m0p, rop, b0.cf, b0.zf, b0.run, 1'b0, e0, n0s, n0p);
            check("rand_er1", obs1, e1);
            check("rand_er0", obs0, e0);
            check("drv_er1", 21'($countones(drv1) > 1), 21'h0);
            check("drv_er0", 21'($countones(drv0) > 1), 21'h0);
            tick();
            m1s = n1s; m1p = n1p; m0s = n0s; m0p = n0p;
            if (m1s == 2 || m0s == 2) hc++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
